// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch sequencer feeding a DEPTH-entry instruction queue
// Optional macro IF_WINDOW_CHK_EN: fault when a fetch leaves the 2 KiB instruction window.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [10:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_fault
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t           state;
  logic [31:0]      pc;
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fault_q;

  logic full;
  logic pop;
  logic can_push;
  logic win_err;
  logic push;
  logic enter_fault;

  // A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    full     = (count == FULL_CNT);
    pop      = (count != '0) && i_ready && !i_redirect;
    can_push = (state == ST_RUN) && !i_redirect && (!full || pop);
`ifdef IF_WINDOW_CHK_EN
    win_err  = (pc[31:11] != 21'd0);
`else
    win_err  = 1'b0;
`endif
    push        = can_push && !win_err;
    enter_fault = (state == ST_RUN) &&
                  ((i_redirect && (i_redirect_pc[1:0] != 2'b00)) || (can_push && win_err));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_RUN;
      pc      <= RESET_PC;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= NOP_INSTR;
        pc_q[i]    <= RESET_PC;
      end
    end else begin
      if (enter_fault) begin
        state   <= ST_FAULT;
        fault_q <= 1'b1;
      end
      if (i_redirect) begin
        // Flush regardless of state; a faulted fetcher keeps its pc frozen.
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        if (state == ST_RUN) begin
          pc <= i_redirect_pc;
        end
      end else begin
        if (push) begin
          instr_q[wr_ptr] <= i_imem_rdata;
          pc_q[wr_ptr]    <= pc;
          wr_ptr          <= wr_ptr + PTR_W'(1);
          pc              <= pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  assign o_imem_addr = pc[10:0];
  assign o_valid     = (count != '0);
  assign o_instr     = instr_q[rd_ptr];
  assign o_pc        = pc_q[rd_ptr];
  assign o_fault     = fault_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue against a queue-based model
module tb_if_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [10:0] o_imem_addr;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_fault;

  logic [31:0] mem [512];

  int vectors;
  int miscompares;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_fault;

  if_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rdata  (i_imem_rdata),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_fault       (o_fault)
  );

  assign i_imem_rdata = mem[o_imem_addr[10:2]];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    mq.delete();
    m_pc    = RESET_PC;
    m_fault = 1'b0;
  endtask

  // One clock of architectural behaviour, evaluated from the pre-edge model state.
  task automatic model_step(input logic rd, input logic [31:0] rpc, input logic rdy);
    logic popd;
    logic room;
    ent_t e;
    if (rd) begin
      mq.delete();
      if (!m_fault) begin
        if (rpc[1:0] != 2'b00) m_fault = 1'b1;
        m_pc = rpc;
      end
    end else begin
      popd = (mq.size() != 0) && rdy;
      room = (mq.size() < DEPTH) || popd;
      if (popd) void'(mq.pop_front());
      if (!m_fault && room) begin
`ifdef IF_WINDOW_CHK_EN
        if (m_pc[31:11] != 0) begin
          m_fault = 1'b1;
        end else begin
          e.pc = m_pc; e.instr = mem[m_pc[10:2]]; mq.push_back(e); m_pc = m_pc + 32'd4;
        end
`else
        e.pc = m_pc; e.instr = mem[m_pc[10:2]]; mq.push_back(e); m_pc = m_pc + 32'd4;
`endif
      end
    end
  endtask

  task automatic drive_cycle(input logic rd, input logic [31:0] rpc, input logic rdy);
    i_redirect    = rd;
    i_redirect_pc = rpc;
    i_ready       = rdy;
    model_step(rd, rpc, rdy);
    @(posedge i_clk);
    @(negedge i_clk);
    i_redirect = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n    = 1'b0;
    i_redirect = 1'b0;
    i_ready    = 1'b0;
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    vectors++; if (o_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b expected 0", o_fault); end
    vectors++; if (o_instr !== NOP) begin miscompares++; $display("FAIL reset_instr: got %h expected %h", o_instr, NOP); end
    vectors++; if (o_pc !== RESET_PC) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", o_pc, RESET_PC); end
    vectors++; if (o_imem_addr !== RESET_PC[10:0]) begin miscompares++; $display("FAIL reset_addr: got %h expected %h", o_imem_addr, RESET_PC[10:0]); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    do_reset();
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, o_valid); end
      vectors++; if (o_pc !== 32'(4 * k)) begin miscompares++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, o_pc, 32'(4 * k)); end
      vectors++; if (o_instr !== mem[k]) begin miscompares++; $display("FAIL stream_instr[%0d]: got %h expected %h", k, o_instr, mem[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    do_reset();
    for (int k = 0; k < 5; k++) drive_cycle(1'b0, 32'h0, 1'b0);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b expected 1", o_valid); end
    vectors++; if (o_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head: got %h expected 0", o_pc); end
    vectors++; if (o_imem_addr !== 11'h008) begin miscompares++; $display("FAIL bp_hold_addr: got %h expected 008", o_imem_addr); end
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, 32'h0, 1'b1);
      vectors++; if (o_pc !== exp_pc[k]) begin miscompares++; $display("FAIL bp_resume[%0d]: got %h expected %h", k, o_pc, exp_pc[k]); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    drive_cycle(1'b0, 32'h0, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b0);
    drive_cycle(1'b1, 32'h100, 1'b1);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush: got %b expected 0", o_valid); end
    vectors++; if (o_imem_addr !== 11'h100) begin miscompares++; $display("FAIL redir_addr: got %h expected 100", o_imem_addr); end
    drive_cycle(1'b0, 32'h0, 1'b1);
    vectors++; if (o_pc !== 32'h100) begin miscompares++; $display("FAIL redir_pc: got %h expected 100", o_pc); end
    vectors++; if (o_instr !== mem[9'h40]) begin miscompares++; $display("FAIL redir_instr: got %h expected %h", o_instr, mem[9'h40]); end
  endtask

  task automatic test_misaligned();
    do_reset();
    drive_cycle(1'b0, 32'h0, 1'b0);
    drive_cycle(1'b1, 32'h102, 1'b0);
    vectors++; if (o_fault !== 1'b1) begin miscompares++; $display("FAIL mis_fault: got %b expected 1", o_fault); end
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, 32'h0, 1'b1);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL mis_nopush: got %b expected 0", o_valid); end
    vectors++; if (o_imem_addr !== 11'h102) begin miscompares++; $display("FAIL mis_pc_hold: got %h expected 102", o_imem_addr); end
    drive_cycle(1'b1, 32'h200, 1'b1);
    vectors++; if (o_fault !== 1'b1) begin miscompares++; $display("FAIL mis_sticky: got %b expected 1", o_fault); end
    do_reset();
    vectors++; if (o_fault !== 1'b0) begin miscompares++; $display("FAIL mis_clear: got %b expected 0", o_fault); end
  endtask

  task automatic test_window();
    do_reset();
    drive_cycle(1'b1, 32'h7FC, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b1);
    vectors++; if (o_pc !== 32'h7FC) begin miscompares++; $display("FAIL win_edge_pc: got %h expected 7fc", o_pc); end
    vectors++; if (o_imem_addr !== 11'h000) begin miscompares++; $display("FAIL win_wrap_addr: got %h expected 000", o_imem_addr); end
    drive_cycle(1'b0, 32'h0, 1'b0);
`ifdef IF_WINDOW_CHK_EN
    vectors++; if (o_fault !== 1'b1) begin miscompares++; $display("FAIL win_fault: got %b expected 1", o_fault); end
    vectors++; if (o_pc !== 32'h7FC) begin miscompares++; $display("FAIL win_keep: got %h expected 7fc", o_pc); end
    drive_cycle(1'b0, 32'h0, 1'b1);
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL win_drain: got %b expected 0", o_valid); end
`else
    vectors++; if (o_fault !== 1'b0) begin miscompares++; $display("FAIL win_nofault: got %b expected 0", o_fault); end
    drive_cycle(1'b0, 32'h0, 1'b1);
    vectors++; if (o_pc !== 32'h800) begin miscompares++; $display("FAIL win_pc800: got %h expected 800", o_pc); end
    vectors++; if (o_instr !== mem[0]) begin miscompares++; $display("FAIL win_instr: got %h expected %h", o_instr, mem[0]); end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_cycle(1'b0, 32'h0, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b0);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL ares_pre: got %b expected 1", o_valid); end
    #2;
    i_rst_n = 1'b0;
    #1;
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL ares_valid: got %b expected 0", o_valid); end
    vectors++; if (o_imem_addr !== RESET_PC[10:0]) begin miscompares++; $display("FAIL ares_pc: got %h expected %h", o_imem_addr, RESET_PC[10:0]); end
    vectors++; if (o_instr !== NOP) begin miscompares++; $display("FAIL ares_instr: got %h expected %h", o_instr, NOP); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    int          sel;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (m_fault && ($urandom_range(0, 9) == 0)) do_reset();
      rd  = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 19);
      if (sel == 0)      rpc = {23'd0, 7'($urandom_range(0, 127)), 2'b10};
      else if (sel < 3)  rpc = 32'h0000_07F0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      else if (sel < 5)  rpc = 32'hFFFF_FFF8;
      else               rpc = {21'd0, 9'($urandom_range(0, 511)), 2'b00};
      rdy = ($urandom_range(0, 3) != 0);
      drive_cycle(rd, rpc, rdy);
      vectors++; if (o_valid !== (mq.size() != 0)) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, o_valid, mq.size() != 0); end
      vectors++; if (o_fault !== m_fault) begin miscompares++; $display("FAIL rnd_fault[%0d]: got %b expected %b", n, o_fault, m_fault); end
      vectors++; if (o_imem_addr !== m_pc[10:0]) begin miscompares++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, o_imem_addr, m_pc[10:0]); end
      if (mq.size() != 0) begin
        vectors++; if (o_pc !== mq[0].pc) begin miscompares++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, o_pc, mq[0].pc); end
        vectors++; if (o_instr !== mq[0].instr) begin miscompares++; $display("FAIL rnd_instr[%0d]: got %h expected %h", n, o_instr, mq[0].instr); end
      end
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    i_rst_n       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_ready       = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_window();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
